key_expansion: RTL and testbench

KEY_EXPANSION -- requirements
Module: key_expansion

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/aes_sbox.sv | 36 +++
 rtl/key_expansion.sv | 154 +++++++++++++++
 tb/tb_key_expansion.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and GF(2^8) helpers used by the key
// schedule and the round datapath.
package aes_pkg;

  localparam int         NUM_ROUNDS_DEF = 10;
  localparam int         STATE_W        = 128;
  localparam logic [7:0] RCON_INIT      = 8'h01;
  localparam logic [7:0] GF_POLY        = 8'h1B;
  localparam logic [7:0] SBOX_AFFINE    = 8'h63;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_FIN  = 2'd2
  } ks_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    logic [7:0] r;
    r = {a[6:0], 1'b0};
    if (a[7]) begin
      r = r ^ GF_POLY;
    end else begin
      r = r;
    end
    return r;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ x;
      end else begin
        p = p;
      end
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform. Shared by the key schedule and the SubBytes stage.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  logic [7:0] w_x2, w_x4, w_x8, w_x16, w_x32, w_x64, w_x128;
  logic [7:0] w_p1, w_p2, w_p3, w_p4, w_p5, w_inv;

  // Inverse as x^254 = x^2 * x^4 * ... * x^128; zero maps to zero.
  assign w_x2   = gf_mul(i_byte, i_byte);
  assign w_x4   = gf_mul(w_x2, w_x2);
  assign w_x8   = gf_mul(w_x4, w_x4);
  assign w_x16  = gf_mul(w_x8, w_x8);
  assign w_x32  = gf_mul(w_x16, w_x16);
  assign w_x64  = gf_mul(w_x32, w_x32);
  assign w_x128 = gf_mul(w_x64, w_x64);

  assign w_p1  = gf_mul(w_x2, w_x4);
  assign w_p2  = gf_mul(w_p1, w_x8);
  assign w_p3  = gf_mul(w_p2, w_x16);
  assign w_p4  = gf_mul(w_p3, w_x32);
  assign w_p5  = gf_mul(w_p4, w_x64);
  assign w_inv = gf_mul(w_p5, w_x128);

  assign o_byte = w_inv
                ^ {w_inv[6:0], w_inv[7]}
                ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]}
                ^ {w_inv[3:0], w_inv[7:4]}
                ^ SBOX_AFFINE;

endmodule

// File: rtl/key_expansion.sv
// AES-128 key schedule streaming round keys 0..NUM_ROUNDS over a valid/ready
// handshake. Define KEY_EXPANSION_STORE_EN to keep a readable copy of the schedule.
module key_expansion
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         done,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  generate
    if (NUM_ROUNDS != NUM_ROUNDS_DEF) begin : g_bad_rounds
      $error("key_expansion: NUM_ROUNDS must be 10 (AES-128)");
    end
  endgenerate

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  ks_state_t            r_state;
  ks_state_t            w_state_nxt;
  logic [STATE_W-1:0]   r_rk_out;
  logic [3:0]           r_rk_idx;
  logic [7:0]           r_rcon;
  logic                 w_accept;
  logic                 w_hs;
  logic [31:0]          w_w0, w_w1, w_w2, w_w3;
  logic [31:0]          w_rot, w_sub, w_t;
  logic [31:0]          w_n0, w_n1, w_n2, w_n3;
  logic [STATE_W-1:0]   w_next_key;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_hs     = (r_state == ST_EMIT) && rk_ready;

  // Next-key datapath: one schedule step computed from the key on display.
  assign w_w0  = r_rk_out[127:96];
  assign w_w1  = r_rk_out[95:64];
  assign w_w2  = r_rk_out[63:32];
  assign w_w3  = r_rk_out[31:0];
  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_rot[8*g +: 8]),
      .o_byte (w_sub[8*g +: 8])
    );
  end

  assign w_t        = w_sub ^ {r_rcon, 24'h000000};
  assign w_n0       = w_w0 ^ w_t;
  assign w_n1       = w_w1 ^ w_n0;
  assign w_n2       = w_w2 ^ w_n1;
  assign w_n3       = w_w3 ^ w_n2;
  assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_EMIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (rk_ready && (r_rk_idx == LAST_IDX)) begin
          w_state_nxt = ST_FIN;
        end else begin
          w_state_nxt = ST_EMIT;
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Round key, index and rcon registers; they hold while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rk_out <= 128'h0;
      r_rk_idx <= 4'h0;
      r_rcon   <= RCON_INIT;
    end else if (w_accept) begin
      r_rk_out <= key_in;
      r_rk_idx <= 4'h0;
      r_rcon   <= RCON_INIT;
    end else if (w_hs && (r_rk_idx != LAST_IDX)) begin
      r_rk_out <= w_next_key;
      r_rk_idx <= r_rk_idx + 4'h1;
      r_rcon   <= xtime(r_rcon);
    end
  end

  assign rk_valid = (r_state == ST_EMIT);
  assign busy     = (r_state == ST_EMIT) || (r_state == ST_FIN);
  assign done     = (r_state == ST_FIN);
  assign rk_idx   = r_rk_idx;
  assign rk_out   = r_rk_out;

`ifdef KEY_EXPANSION_STORE_EN
  logic [STATE_W-1:0] r_store [0:NUM_ROUNDS];

  // Schedule copy: cleared on reset and on a new expansion, filled per handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        r_store[i] <= 128'h0;
      end
    end else if (w_accept) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        r_store[i] <= 128'h0;
      end
    end else if (w_hs) begin
      r_store[r_rk_idx] <= r_rk_out;
    end
  end

  // Read port; indices past the last round read as zero.
  always_comb begin
    rd_key = 128'h0;
    if (rd_idx <= LAST_IDX) begin
      rd_key = r_store[rd_idx];
    end else begin
      rd_key = 128'h0;
    end
  end
`else
  logic w_unused_rd;
  assign w_unused_rd = ^rd_idx;
  assign rd_key      = 128'h0;
`endif

endmodule

// File: tb/tb_key_expansion.sv
// Directed bench for key_expansion: FIPS-197 schedules, stalls, ignored starts,
// mid-run reset and the optional stored-schedule read port.
module tb_key_expansion;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         done;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  key_expansion dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_idx   (rk_idx),
    .rk_out   (rk_out),
    .done     (done),
    .rd_idx   (rd_idx),
    .rd_key   (rd_key)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] fips_rk(input int idx);
    case (idx)
      0:       return 128'h2b7e151628aed2a6abf7158809cf4f3c;
      1:       return 128'ha0fafe1788542cb123a339392a6c7605;
      2:       return 128'hf2c295f27a96b9435935807a7359f67f;
      3:       return 128'h3d80477d4716fe3e1e237e446d7a883b;
      4:       return 128'hef44a541a8525b7fb671253bdb0bad00;
      5:       return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      6:       return 128'h6d88a37a110b3efddbf98641ca0093fd;
      7:       return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      8:       return 128'head27321b58dbad2312bf5607f8d292f;
      9:       return 128'hac7766f319fadc2128d12941575c006e;
      10:      return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      default: return 128'h0;
    endcase
  endfunction

  // mode 0: ready always high; 1: random ready; 2: ready high plus stray starts.
  task automatic run_key(input logic [127:0] key, input int mode);
    int   cyc;
    int   exp_idx;
    logic got_done;
    logic known;
    logic [127:0] exp_key;
    @(negedge clk);
    key_in   = key;
    start    = 1'b1;
    rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 128'(busy), 128'd1);
    cyc      = 1;
    exp_idx  = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 200) begin
      start = 1'b0;
      if (done) begin
        got_done = 1'b1;
        check("rk_valid_in_fin", 128'(rk_valid), 128'd0);
        check("busy_in_fin", 128'(busy), 128'd1);
        check("keys_emitted", 128'(exp_idx), 128'd11);
        if (mode != 1) check("done_latency", 128'(cyc), 128'd12);
        if (mode == 2) begin
          start  = 1'b1;
          key_in = 128'hffffffffffffffffffffffffffffffff;
        end
      end else begin
        check($sformatf("rk_valid_%0d", exp_idx), 128'(rk_valid), 128'd1);
        check($sformatf("rk_idx_%0d", exp_idx), 128'(rk_idx), 128'(exp_idx));
        if (key == K1) begin
          known   = 1'b1;
          exp_key = fips_rk(exp_idx);
        end else if (exp_idx == 0) begin
          known   = 1'b1;
          exp_key = key;
        end else if (exp_idx == 1) begin
          known   = 1'b1;
          exp_key = K2_R1;
        end else if (exp_idx == 10) begin
          known   = 1'b1;
          exp_key = K2_R10;
        end else begin
          known   = 1'b0;
          exp_key = 128'h0;
        end
        if (known) check($sformatf("rk_out_%0d", exp_idx), rk_out, exp_key);
        if (mode == 2 && exp_idx == 4) begin
          start  = 1'b1;
          key_in = 128'h0;
        end
        rk_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rk_ready) exp_idx++;
        @(negedge clk);
        cyc++;
      end
    end
    check("done_seen", 128'(got_done), 128'd1);
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", 128'(done), 128'd0);
    check("busy_after_fin", 128'(busy), 128'd0);
    @(negedge clk);
    check("idle_busy", 128'(busy), 128'd0);
    check("idle_valid", 128'(rk_valid), 128'd0);
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    start    = 1'b0;
    key_in   = 128'h0;
    rk_ready = 1'b0;
    rd_idx   = 4'd0;
    #1;
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_valid", 128'(rk_valid), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_idx", 128'(rk_idx), 128'd0);
    check("rst_key", rk_out, 128'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_key(K1, 0);
    rd_idx = 4'd10;
    #1;
`ifdef KEY_EXPANSION_STORE_EN
    check("rd_idx10", rd_key, fips_rk(10));
    rd_idx = 4'd0;
    #1;
    check("rd_idx0", rd_key, K1);
`else
    check("rd_idx10_off", rd_key, 128'h0);
`endif
    rd_idx = 4'd15;
    #1;
    check("rd_idx15", rd_key, 128'h0);

    run_key(K1, 1);
    run_key(K1, 2);

    @(negedge clk);
    key_in   = K1;
    start    = 1'b1;
    rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (rk_idx != 4'd6 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("reached_idx6", 128'(rk_idx), 128'd6);
    rst = 1'b1;
    #1;
    check("midrst_valid", 128'(rk_valid), 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_done", 128'(done), 128'd0);
    check("midrst_idx", 128'(rk_idx), 128'd0);
    check("midrst_key", rk_out, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("no_done_after_rst_%0d", i), 128'(done), 128'd0);
    end
    rd_idx = 4'd10;
    #1;
    check("rd_cleared", rd_key, 128'h0);

    run_key(K2, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
